// File: rtl/uart_pkg.sv
// Shared definitions for the hex-dump UART front end: controller states,
// line-terminator characters and the nibble-to-ASCII encoder.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_IDLE
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a registered read
// port: o_rd_data holds the word popped on the previous edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_rd_data;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_count_nxt;

    // A push is refused while full even if a pop happens in the same cycle.
    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_rd_data <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule

// File: rtl/uart_hex_tx.sv
// Buffers words and prints each one as uppercase hex (MS nibble first),
// optionally followed by CR LF, handshaking character by character with a UART.
module uart_hex_tx
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int NEWLINE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] in_dat,
    input  logic                  in_val,
    output logic                  in_rdy,
    output logic [7:0]            txd,
    output logic                  txv,
    input  logic                  rdy,
    output logic                  busy
);

    localparam int NIBBLES = WORD_WIDTH / 4;
    localparam int NCHARS  = NIBBLES + ((NEWLINE != 0) ? 2 : 0);
    localparam int IW      = $clog2(NCHARS + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] r_shift;
    logic [IW-1:0]         r_idx;
    logic                  r_txv;
    logic [7:0]            r_txd;

    logic                  w_pop;
    logic                  w_load;
    logic                  w_send;
    logic                  w_advance;
    logic [7:0]            w_char;
    logic [WORD_WIDTH-1:0] w_fifo_data;
    logic                  w_full;
    logic                  w_empty;

    sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (in_val),
        .i_wr_data (in_dat),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_send      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = SEND;
            end
            SEND: begin
                if (rdy) begin
                    w_send      = 1'b1;
                    w_state_nxt = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!rdy)
                    w_state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (rdy) begin
                    if (r_idx == IW'(NCHARS - 1)) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = SEND;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Hex digits come off the top of the shift register; terminator slots follow.
    always_comb begin
        w_char = nibble_to_ascii(r_shift[WORD_WIDTH-1 -: 4]);
        if (NEWLINE != 0) begin
            if (r_idx == IW'(NIBBLES))
                w_char = ASCII_CR;
            else if (r_idx == IW'(NIBBLES + 1))
                w_char = ASCII_LF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_txv   <= 1'b0;
            r_txd   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_txv   <= w_send;
            if (w_send)
                r_txd <= w_char;
            if (w_load) begin
                r_shift <= w_fifo_data;
                r_idx   <= '0;
            end else if (w_advance) begin
                r_shift <= r_shift << 4;
                r_idx   <= r_idx + IW'(1);
            end
        end
    end

    assign in_rdy = ~w_full;
    assign txv    = r_txv;
    assign txd    = r_txd;
    assign busy   = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Directed scenarios on three configurations (32-bit/CRLF, 32-bit/no
// terminator, 8-bit/CRLF) against a scoreboard of expected characters.
module tb_uart_hex_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] dat      [3];
    logic        val      [3];
    logic        in_rdy_w [3];
    logic [7:0]  txd_w    [3];
    logic        txv_w    [3];
    logic        busy_w   [3];
    logic        rdy_m    [3];
    logic        stall    [3];
    logic        prev_txv [3];
    int          cnt      [3];
    int          strb     [3];
    logic [7:0]  exp_q    [3][$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_hex_tx #(.WORD_WIDTH(32), .FIFO_DEPTH(4), .NEWLINE(1)) dut0 (
        .clk(clk), .rst(rst), .in_dat(dat[0][31:0]), .in_val(val[0]), .in_rdy(in_rdy_w[0]),
        .txd(txd_w[0]), .txv(txv_w[0]), .rdy(rdy_m[0]), .busy(busy_w[0]));

    uart_hex_tx #(.WORD_WIDTH(32), .FIFO_DEPTH(4), .NEWLINE(0)) dut1 (
        .clk(clk), .rst(rst), .in_dat(dat[1][31:0]), .in_val(val[1]), .in_rdy(in_rdy_w[1]),
        .txd(txd_w[1]), .txv(txv_w[1]), .rdy(rdy_m[1]), .busy(busy_w[1]));

    uart_hex_tx #(.WORD_WIDTH(8), .FIFO_DEPTH(4), .NEWLINE(1)) dut2 (
        .clk(clk), .rst(rst), .in_dat(dat[2][7:0]), .in_val(val[2]), .in_rdy(in_rdy_w[2]),
        .txd(txd_w[2]), .txv(txv_w[2]), .rdy(rdy_m[2]), .busy(busy_w[2]));

    assign rdy_m[0] = !stall[0] && (cnt[0] == 0);
    assign rdy_m[1] = !stall[1] && (cnt[1] == 0);
    assign rdy_m[2] = !stall[2] && (cnt[2] == 0);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h41 + {4'h0, nib} - 8'd10;
    endfunction

    function automatic int wid(input int k);
        return (k == 2) ? 8 : 32;
    endfunction

    // UART model: each strobe holds rdy low for 10 cycles; also the monitor.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (txv_w[k] === 1'b1) begin
                check($sformatf("txv_while_rdy_low[%0d]", k), {63'd0, rdy_m[k]}, 64'd1);
                check($sformatf("txv_back_to_back[%0d]", k), {63'd0, prev_txv[k]}, 64'd0);
                check($sformatf("unexpected_char[%0d]", k), {63'd0, exp_q[k].size() != 0}, 64'd1);
                if (exp_q[k].size() != 0)
                    check($sformatf("txd[%0d]", k), {56'd0, txd_w[k]}, {56'd0, exp_q[k].pop_front()});
                strb[k] = strb[k] + 1;
                cnt[k]  = 10;
            end else if (cnt[k] > 0) begin
                cnt[k] = cnt[k] - 1;
            end
            prev_txv[k] = txv_w[k];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int k, input logic [63:0] w);
        for (int i = wid(k) / 4 - 1; i >= 0; i--)
            exp_q[k].push_back(hexc(w[4*i +: 4]));
        if (k != 1) begin
            exp_q[k].push_back(8'h0D);
            exp_q[k].push_back(8'h0A);
        end
    endtask

    task automatic push_word(input int k, input logic [63:0] w, output logic acc);
        acc    = in_rdy_w[k];
        dat[k] = w;
        val[k] = 1'b1;
        tick();
        val[k] = 1'b0;
        if (acc)
            push_exp(k, w);
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n = 0;
        while ((busy_w[k] || exp_q[k].size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("idle_timeout[%0d]", k), {63'd0, n < budget}, 64'd1);
        check($sformatf("busy_end[%0d]", k), {63'd0, busy_w[k]}, 64'd0);
    endtask

    task automatic wait_strb(input int k, input int target, input int budget);
        int n = 0;
        while (strb[k] < target && n < budget) begin
            tick();
            n++;
        end
        check($sformatf("strobe_timeout[%0d]", k), {63'd0, n < budget}, 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   base;
        int   lat;
        int   n_acc;

        for (int k = 0; k < 3; k++) begin
            dat[k]      = '0;
            val[k]      = 1'b0;
            stall[k]    = 1'b0;
            cnt[k]      = 0;
            strb[k]     = 0;
            prev_txv[k] = 1'b0;
        end
        rst = 1'b1;
        // in_val during reset must be ignored
        dat[0] = 64'hCAFE_F00D;
        val[0] = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_busy[%0d]", k), {63'd0, busy_w[k]}, 64'd0);
            check($sformatf("rst_in_rdy[%0d]", k), {63'd0, in_rdy_w[k]}, 64'd1);
            check($sformatf("rst_txv[%0d]", k), {63'd0, txv_w[k]}, 64'd0);
            check($sformatf("rst_txd[%0d]", k), {56'd0, txd_w[k]}, 64'd0);
        end
        rst    = 1'b0;
        val[0] = 1'b0;
        repeat (5) tick();
        check("ignored_in_val_busy", {63'd0, busy_w[0]}, 64'd0);
        check("ignored_in_val_strb", strb[0], 0);

        // DEADBEEF with CR LF, plus first-strobe latency
        base = strb[0];
        push_word(0, 64'hDEAD_BEEF, acc);
        check("deadbeef_accepted", {63'd0, acc}, 64'd1);
        lat = 1;
        while (!txv_w[0] && lat < 20) begin
            tick();
            lat++;
        end
        check("first_txv_seen", {63'd0, lat < 20}, 64'd1);
        check("first_txv_latency_ge3", {63'd0, lat >= 3}, 64'd1);
        wait_idle(0, 1000);
        check("deadbeef_strobes", strb[0] - base, 10);

        // No terminator configuration
        base = strb[1];
        push_word(1, 64'h0000_000F, acc);
        wait_idle(1, 1000);
        check("nonl_strobes", strb[1] - base, 8);

        // Long stall in SEND
        stall[0] = 1'b1;
        base = strb[0];
        push_word(0, 64'h0000_00C3, acc);
        repeat (100) tick();
        check("stall_no_txv", strb[0] - base, 0);
        check("stall_busy", {63'd0, busy_w[0]}, 64'd1);
        stall[0] = 1'b0;
        tick();
        check("stall_release_txv", {63'd0, txv_w[0]}, 64'd1);
        wait_idle(0, 1000);

        // Six back-to-back pushes into a stalled UART
        stall[0] = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            acc    = in_rdy_w[0];
            dat[0] = 64'h1111_0000 + 64'(i);
            val[0] = 1'b1;
            tick();
            if (acc) begin
                n_acc++;
                push_exp(0, 64'h1111_0000 + 64'(i));
            end
        end
        val[0] = 1'b0;
        check("burst_accepted", n_acc, 5);
        check("burst_in_rdy", {63'd0, in_rdy_w[0]}, 64'd0);
        stall[0] = 1'b0;
        wait_idle(0, 5000);

        // Push coinciding with a pop at occupancy 2
        base = strb[0];
        push_word(0, 64'hA0A0_A0A0, acc);
        push_word(0, 64'hB1B1_B1B1, acc);
        push_word(0, 64'hC2C2_C2C2, acc);
        wait_strb(0, base + 10, 1000);
        stall[0] = 1'b1;
        repeat (20) tick();
        stall[0] = 1'b0;
        tick();
        push_word(0, 64'hD3D3_D3D3, acc);
        stall[0] = 1'b1;
        check("pushpop_accepted", {63'd0, acc}, 64'd1);
        n_acc = 0;
        for (int i = 0; i < 3; i++) begin
            push_word(0, 64'hE000_0000 + 64'(i), acc);
            if (acc)
                n_acc++;
        end
        check("pushpop_room_left", n_acc, 2);
        check("pushpop_full", {63'd0, in_rdy_w[0]}, 64'd0);
        stall[0] = 1'b0;
        wait_idle(0, 5000);

        // Reset in the middle of a word with another buffered
        base = strb[0];
        push_word(0, 64'h1234_5678, acc);
        push_word(0, 64'h5555_0000, acc);
        wait_strb(0, base + 3, 1000);
        rst = 1'b1;
        for (int k = 0; k < 3; k++)
            exp_q[k].delete();
        tick();
        check("midrst_txv", {63'd0, txv_w[0]}, 64'd0);
        check("midrst_busy", {63'd0, busy_w[0]}, 64'd0);
        check("midrst_in_rdy", {63'd0, in_rdy_w[0]}, 64'd1);
        check("midrst_txd", {56'd0, txd_w[0]}, 64'd0);
        rst = 1'b0;
        repeat (40) tick();
        check("midrst_no_more_chars", strb[0] - base, 3);
        check("midrst_still_idle", {63'd0, busy_w[0]}, 64'd0);

        base = strb[2];
        push_word(2, 64'hA5, acc);
        wait_idle(2, 1000);
        check("byte_strobes", strb[2] - base, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
